// File: rtl/recon_block_reader_pkg.sv
// intra_pkg: shared pixel type, reader FSM states and constants for recon_block_reader (RECON_NEIGHBOUR_FETCH_EN selects the neighbour build)
package intra_pkg;
  typedef logic [7:0] pix_t;
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, NBR, PRESENT, DONE} rbr_state_t;
  localparam int BLK4 = 4;
  localparam pix_t PIX_DEFAULT = 8'd128;
endpackage

// File: rtl/recon_block_reader_if.sv
// recon_block_reader_if: frame-store read port (mem_rd_en/mem_addr/mem_rdata) and block stream (blk_*) plus neighbour outputs under RECON_NEIGHBOUR_FETCH_EN; master = reader, slave = memory/consumer
interface recon_block_reader_if import intra_pkg::*; #(parameter int AW = 20);
  logic mem_rd_en;
  logic [AW-1:0] mem_addr;
  pix_t mem_rdata;
  logic blk_valid, blk_ready;
  logic [127:0] blk_pixels;
  logic [15:0] blk_row, blk_col;
`ifdef RECON_NEIGHBOUR_FETCH_EN
  logic [31:0] nbr_top, nbr_left;
  pix_t nbr_tl;
  logic nbr_top_avail, nbr_left_avail;
  modport master (output mem_rd_en, mem_addr, blk_valid, blk_pixels, blk_row, blk_col, nbr_top, nbr_left, nbr_tl, nbr_top_avail, nbr_left_avail, input mem_rdata, blk_ready);
  modport slave (input mem_rd_en, mem_addr, blk_valid, blk_pixels, blk_row, blk_col, nbr_top, nbr_left, nbr_tl, nbr_top_avail, nbr_left_avail, output mem_rdata, blk_ready);
`else
  modport master (output mem_rd_en, mem_addr, blk_valid, blk_pixels, blk_row, blk_col, input mem_rdata, blk_ready);
  modport slave (input mem_rd_en, mem_addr, blk_valid, blk_pixels, blk_row, blk_col, output mem_rdata, blk_ready);
`endif
endinterface

// File: rtl/recon_block_reader_addr_gen.sv
// recon_addr_gen: block coordinates + in-block/neighbour offset -> addr row*WIDTH+col; ports clk/reset, step_i/clr_i offset control, adv_i next block, off_o/row_o/col_o/addr_o/last_block_o (+in_frame_o under RECON_NEIGHBOUR_FETCH_EN)
module recon_addr_gen #(
  parameter int WIDTH = 800,
  parameter int LENGTH = 800,
  parameter int BLK = 4,
  parameter int AW = $clog2(WIDTH*LENGTH)
) (
  input  logic clk,
  input  logic reset,
  input  logic step_i,
  input  logic clr_i,
  input  logic adv_i,
  output logic [4:0] off_o,
  output logic [15:0] row_o,
  output logic [15:0] col_o,
  output logic [AW-1:0] addr_o,
  output logic last_block_o
`ifdef RECON_NEIGHBOUR_FETCH_EN
  , output logic in_frame_o
`endif
);
  logic [15:0] row_q, col_q, r, c;
  logic [4:0] off_q;
  logic last_in_row;
`ifdef RECON_NEIGHBOUR_FETCH_EN
  logic top_s, left_s, tl_s;
  always_comb begin
    top_s = off_q[4:2] == 3'b100;
    left_s = off_q[4:2] == 3'b101;
    tl_s = off_q[4:3] == 2'b11;
    r = (top_s || tl_s) ? row_q - 16'd1 : row_q + 16'(left_s ? off_q[1:0] : off_q[3:2]);
    c = (left_s || tl_s) ? col_q - 16'd1 : col_q + 16'(off_q[1:0]);
    in_frame_o = !((top_s || tl_s) && row_q == '0) && !((left_s || tl_s) && col_q == '0);
  end
`else
  assign r = row_q + 16'(off_q[3:2]);
  assign c = col_q + 16'(off_q[1:0]);
`endif
  assign addr_o = AW'(r) * AW'(WIDTH) + AW'(c);
  assign last_in_row = col_q == 16'(WIDTH - BLK);
  assign last_block_o = last_in_row && row_q == 16'(LENGTH - BLK);
  assign off_o = off_q;
  assign row_o = row_q;
  assign col_o = col_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      row_q <= '0;
      col_q <= '0;
      off_q <= '0;
    end else begin
      off_q <= clr_i ? '0 : off_q + 5'(step_i);
      if (adv_i) begin
        col_q <= last_in_row ? '0 : col_q + 16'(BLK);
        row_q <= last_in_row ? row_q + 16'(BLK) : row_q;
      end
    end
  end
endmodule

// File: rtl/recon_block_reader.sv
// recon_block_reader: streams the frame store as 4x4 blocks in block-raster order; ports clk, reset (sync, high), enable (start, IDLE only), done (sticky), bus master (mem read + blk valid/ready stream); RECON_NEIGHBOUR_FETCH_EN adds the neighbour fetch
module recon_block_reader import intra_pkg::*; #(
  parameter int WIDTH = 800,
  parameter int LENGTH = 800,
  parameter int BLK = 4,
  parameter int AW = $clog2(WIDTH*LENGTH)
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic done,
  recon_block_reader_if.master bus
);
`ifdef RECON_NEIGHBOUR_FETCH_EN
  localparam int NSLOT = 25;
  logic in_frame;
`else
  localparam int NSLOT = 16;
`endif
  localparam int SW = $clog2(NSLOT);
  rbr_state_t state_q, state_d;
  pix_t [NSLOT-1:0] cap_q;
  logic [SW-1:0] slot_q;
  logic rd_q, dflt_q, rd_en, dflt, step, adv, last_block;
  logic [4:0] off;
  logic [15:0] row, col;
  logic [AW-1:0] addr;
  recon_addr_gen #(.WIDTH(WIDTH), .LENGTH(LENGTH), .BLK(BLK), .AW(AW)) u_addr (
    .clk(clk), .reset(reset), .step_i(step), .clr_i(state_q == PRESENT), .adv_i(adv),
    .off_o(off), .row_o(row), .col_o(col), .addr_o(addr), .last_block_o(last_block)
`ifdef RECON_NEIGHBOUR_FETCH_EN
    , .in_frame_o(in_frame)
`endif
  );
  always_comb begin
    state_d = state_q;
    step = 1'b0;
    rd_en = 1'b0;
    dflt = 1'b0;
    case (state_q)
      IDLE: state_d = enable ? FETCH : IDLE;
      FETCH: begin
        step = 1'b1;
        rd_en = 1'b1;
        state_d = off == 5'd15 ? WAIT : FETCH;
      end
`ifdef RECON_NEIGHBOUR_FETCH_EN
      // neighbour reads start in WAIT so the top-left read lands inside NBR's ninth cycle
      WAIT, NBR: begin
        step = 1'b1;
        rd_en = in_frame && off <= 5'd24;
        dflt = !in_frame && off <= 5'd24;
        state_d = state_q == WAIT ? NBR : off == 5'd25 ? PRESENT : NBR;
      end
`else
      WAIT: state_d = PRESENT;
`endif
      PRESENT: state_d = bus.blk_ready ? (last_block ? DONE : FETCH) : PRESENT;
      default: ;
    endcase
  end
  assign adv = state_q == PRESENT && bus.blk_ready && !last_block;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cap_q <= '0;
      slot_q <= '0;
      rd_q <= 1'b0;
      dflt_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_q <= rd_en;
      dflt_q <= dflt;
      slot_q <= SW'(off);
      if (rd_q) cap_q[slot_q] <= bus.mem_rdata;
      else if (dflt_q) cap_q[slot_q] <= PIX_DEFAULT;
    end
  end
  assign bus.mem_rd_en = rd_en;
  assign bus.mem_addr = rd_en ? addr : '0;
  assign bus.blk_valid = state_q == PRESENT;
  assign bus.blk_pixels = cap_q[BLK4*BLK4-1:0];
  assign bus.blk_row = row;
  assign bus.blk_col = col;
  assign done = state_q == DONE;
`ifdef RECON_NEIGHBOUR_FETCH_EN
  assign bus.nbr_top = cap_q[19:16];
  assign bus.nbr_left = cap_q[23:20];
  assign bus.nbr_tl = cap_q[24];
  assign bus.nbr_top_avail = row != '0;
  assign bus.nbr_left_avail = col != '0;
`endif
endmodule

// File: tb/tb_recon_block_reader.sv
// tb_recon_block_reader: scoreboard bench for recon_block_reader on an 8x8 frame with mem[a]=a
module tb_recon_block_reader;
  import intra_pkg::*;
`ifdef RECON_NEIGHBOUR_FETCH_EN
  localparam int LAT = 27;
`else
  localparam int LAT = 18;
`endif
  typedef struct {
    logic [15:0] row, col;
    logic [127:0] pix;
`ifdef RECON_NEIGHBOUR_FETCH_EN
    logic [31:0] top, left;
    logic [7:0] tl;
    logic ta, la;
`endif
  } exp_t;
  logic clk = 1'b0, reset = 1'b1, enable = 1'b0, done;
  int cyc = 0, checks = 0, passes = 0;
  exp_t sb[$];
  exp_t mon_e;
  recon_block_reader_if #(.AW(6)) bus();
  recon_block_reader #(.WIDTH(8), .LENGTH(8), .BLK(4), .AW(6)) dut (
    .clk(clk), .reset(reset), .enable(enable), .done(done), .bus(bus.master)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) bus.mem_rdata <= bus.mem_rd_en ? {2'b00, bus.mem_addr} : 8'hee;
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  function automatic exp_t blk_exp(input int n);
    exp_t e;
    e = '{default: '0};
    case (n)
      0: begin e.row = 0; e.col = 0; e.pix = 128'h1b1a1918_13121110_0b0a0908_03020100; end
      1: begin e.row = 0; e.col = 4; e.pix = 128'h1f1e1d1c_17161514_0f0e0d0c_07060504; end
      2: begin e.row = 4; e.col = 0; e.pix = 128'h3b3a3938_33323130_2b2a2928_23222120; end
      default: begin e.row = 4; e.col = 4; e.pix = 128'h3f3e3d3c_37363534_2f2e2d2c_27262524; end
    endcase
`ifdef RECON_NEIGHBOUR_FETCH_EN
    case (n)
      0: begin e.top = 32'h80808080; e.left = 32'h80808080; e.tl = 8'h80; e.ta = 0; e.la = 0; end
      1: begin e.top = 32'h80808080; e.left = 32'h1b130b03; e.tl = 8'h80; e.ta = 0; e.la = 1; end
      2: begin e.top = 32'h1b1a1918; e.left = 32'h80808080; e.tl = 8'h80; e.ta = 1; e.la = 0; end
      default: begin e.top = 32'h1f1e1d1c; e.left = 32'h3b332b23; e.tl = 8'h1b; e.ta = 1; e.la = 1; end
    endcase
`endif
    return e;
  endfunction
  always @(negedge clk) begin
    if (!reset && bus.blk_valid && bus.blk_ready) begin
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL sb_unexpected: block (%0d,%0d) presented, none expected", bus.blk_row, bus.blk_col);
      end else begin
        mon_e = sb.pop_front();
        chk("blk_row", bus.blk_row, mon_e.row);
        chk("blk_col", bus.blk_col, mon_e.col);
        chk("blk_pixels", bus.blk_pixels, mon_e.pix);
`ifdef RECON_NEIGHBOUR_FETCH_EN
        chk("nbr_top", bus.nbr_top, mon_e.top);
        chk("nbr_left", bus.nbr_left, mon_e.left);
        chk("nbr_tl", bus.nbr_tl, mon_e.tl);
        chk("nbr_avail", {bus.nbr_top_avail, bus.nbr_left_avail}, {mon_e.ta, mon_e.la});
`endif
      end
    end
  end
  task automatic check_zero(input string tag);
    chk({tag, "_rd_en"}, bus.mem_rd_en, 0);
    chk({tag, "_addr"}, bus.mem_addr, 0);
    chk({tag, "_valid"}, bus.blk_valid, 0);
    chk({tag, "_pixels"}, bus.blk_pixels, 0);
    chk({tag, "_row"}, bus.blk_row, 0);
    chk({tag, "_col"}, bus.blk_col, 0);
    chk({tag, "_done"}, done, 0);
  endtask
  task automatic wait_valid(output int t);
    t = -1;
    for (int n = 0; n < 60; n++) begin
      @(posedge clk);
      #1;
      if (bus.blk_valid) begin
        t = cyc;
        return;
      end
    end
    checks++;
    $display("FAIL wait_valid: timeout, blk_valid still 0 expected 1");
  endtask
  task automatic wait_done();
    for (int n = 0; n < 200; n++) begin
      @(posedge clk);
      #1;
      if (done) return;
    end
    checks++;
    $display("FAIL wait_done: timeout, done still 0 expected 1");
  endtask
  task automatic start_frame(output int t0);
    for (int n = 0; n < 4; n++) sb.push_back(blk_exp(n));
    enable = 1'b1;
    t0 = cyc;
    @(posedge clk);
    #1;
    enable = 1'b0;
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int t0, t1, t2;
    bus.blk_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("rst_held");
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_zero("rst_idle");
    bus.blk_ready = 1'b1;
    start_frame(t0);
    wait_valid(t1);
    chk("latency", t1 - t0, LAT);
    @(posedge clk);
    #1;
    bus.blk_ready = 1'b0;
    wait_valid(t2);
    chk("period", t2 - t1, LAT);
    for (int n = 0; n < 5; n++) begin
      @(posedge clk);
      #1;
      chk("stall_valid", bus.blk_valid, 1);
      chk("stall_pixels", bus.blk_pixels, blk_exp(1).pix);
      chk("stall_rd_en", bus.mem_rd_en, 0);
    end
    bus.blk_ready = 1'b1;
    wait_done();
    chk("frame1_drained", sb.size(), 0);
    enable = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk);
      #1;
      chk("done_sticky", done, 1);
      chk("done_rd_en", bus.mem_rd_en, 0);
      chk("done_valid", bus.blk_valid, 0);
    end
    enable = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_zero("rst_from_done");
    enable = 1'b1;
    @(posedge clk);
    #1;
    enable = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("fetch7_rd_en", bus.mem_rd_en, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_zero("rst_mid_fetch");
    reset = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(posedge clk);
      #1;
      chk("idle_rd_en", bus.mem_rd_en, 0);
    end
    start_frame(t0);
    wait_valid(t1);
    chk("restart_latency", t1 - t0, LAT);
    wait_done();
    chk("frame2_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
